accessory_input_sequencer: RTL and testbench
============================================

Name: accessory_input_sequencer

Overview:
Sequences the PL19 accessory input path. It shares the single serial PL19_INPUT line between N_DEV character-oriented input devices (photo tape reader, typewriter), under the START_INPUT/STOP_INPUT pulses and the M20-qualified shift command produced by the control switch. Each accepted device code is serialised MSB-first, one bit per shift-qualified clock. The serial output feeds the control switch's PL19_INPUT; the device side uses a valid/ready handshake.

Parameters:
N_DEV, 2, number of input devices sharing PL19 (2..4)
CODE_W, 5, bits per device character code

Ports:
CLOCK  in  1  system clock; one clock, all state on rising edge
rst  in  1  reset; reset is asynchronous and active-low (asserted when 0)
start_input  in  1  from PL19_START_INPUT; opens an input session
stop_input  in  1  from PL19_STOP_INPUT; requests session close
shift_m20  in  1  from PL19_SHIFT_CMD_M20; one bit is consumed per high cycle
dev_valid  in  N_DEV  device i holds a code
dev_data  in  N_DEV*CODE_W  code of device i at [i*CODE_W +: CODE_W]
dev_ready  out  N_DEV  one-hot accept strobe
PL19_INPUT  out  1  serial bit to control switch
grant  out  $clog2(N_DEV)  index of device owning current character
busy  out  1  session open (state != IDLE)
char_done  out  1  one-cycle pulse after last bit of a character shifts

Behaviour:
- Reset (rst=0, async): state=IDLE, shreg=0, bitcnt=0, stop_pend=0, last_grant=N_DEV-1, grant=0; all outputs 0.
- States: IDLE, ARB, LOAD, SHIFT.
- IDLE: start_input=1 & stop_input=0 -> ARB. start and stop in the same cycle -> stay IDLE; stop alone is ignored.
- ARB: if stop_pend -> IDLE, stop_pend cleared. Else if any dev_valid -> pick the winner round-robin, starting at last_grant+1 (mod N_DEV); register grant and last_grant -> LOAD. Else stay in ARB (waits indefinitely).
- LOAD (exactly 1 cycle): dev_ready[grant]=1 combinationally; shreg<=dev_data[grant]; bitcnt<=CODE_W -> SHIFT.
- Handshake rules: dev_ready is high only in LOAD. Devices must hold valid/data stable until ready. If dev_valid[grant] is 0 in LOAD (protocol violation), data is still captured.
- SHIFT: PL19_INPUT = shreg[CODE_W-1] & shift_m20 & (state==SHIFT). On each edge with shift_m20=1: shreg shifts left (0 in), bitcnt decrements. Cycles with shift_m20=0 hold state.
- When bitcnt goes 1->0: char_done=1 in the following cycle; next state is ARB.
- Latency: start at edge k -> ARB cycle k+1 -> LOAD k+2 (with valid present) -> first bit available from cycle k+3.
- stop_input in ARB/LOAD/SHIFT sets stop_pend. A character in flight is never truncated; the session closes at the next ARB. stop in ARB closes the session next edge.
- start_input while busy is ignored.
- bitcnt width is $clog2(CODE_W+1); no wrap (decrements only in SHIFT while >0).
- Reset mid-character: the partial character is discarded and dev_ready is not re-issued.

Decomposition:
- Package g15_accessory_pkg: typedef enum logic [1:0] acc_seq_state_t {IDLE, ARB, LOAD, SHIFT}; localparams ACC_N_DEV=2, ACC_CODE_W=5.
- Sub-module rr_arbiter (N parameter): inputs req, last; output gnt_idx, any. Purely combinational, reused by later output-side sequencers.

Test Plan:
- Single char: start; dev_valid=01, data0=5'b10110; shift_m20 held 1 -> dev_ready=01 in cycle 2; PL19_INPUT=1,0,1,1,0 in cycles 3-7; char_done in cycle 8; busy stays 1.
- Round robin: both valid, data0=5'h1F, data1=5'h01, three characters -> grant sequence 0,1,0; dev_ready 01,10,01.
- Gapped shift: shift_m20 toggles 1,0,0,1,... -> PL19_INPUT is 0 on low cycles; bits advance only on high cycles; 5 bits total.
- Stop mid-character: stop at second bit -> remaining 3 bits still shift; then ARB -> IDLE; busy=0; no further dev_ready despite valid=11.
- Start+stop same cycle in IDLE -> stays IDLE, busy=0. Start while busy -> no effect.
- Async reset during SHIFT (rst low mid-cycle) -> outputs 0 immediately. After release, start -> grant=0 first (last_grant reset to N_DEV-1).

Source files
------------

// File: rtl/g15_accessory_pkg.sv
// rtl/g15_accessory_pkg.sv - shared types and defaults for the PL19 accessory sequencers
package g15_accessory_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        LOAD  = 2'd2,
        SHIFT = 2'd3
    } acc_seq_state_t;

    localparam int ACC_N_DEV  = 2;
    localparam int ACC_CODE_W = 5;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting after the last winner
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    // Walk offsets from farthest to nearest so the nearest requester after last wins
    always_comb begin
        gnt_idx = '0;
        any     = 1'b0;
        for (int off = N; off >= 1; off--) begin
            if (req[(int'(last) + off) % N]) begin
                gnt_idx = IW'((int'(last) + off) % N);
                any     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/accessory_input_sequencer.sv
// rtl/accessory_input_sequencer.sv - shares PL19_INPUT between character input devices
module accessory_input_sequencer
    import g15_accessory_pkg::*;
#(
    parameter int N_DEV  = ACC_N_DEV,
    parameter int CODE_W = ACC_CODE_W
) (
    input  logic                       CLOCK,
    input  logic                       rst,
    input  logic                       start_input,
    input  logic                       stop_input,
    input  logic                       shift_m20,
    input  logic [N_DEV-1:0]           dev_valid,
    input  logic [N_DEV*CODE_W-1:0]    dev_data,
    output logic [N_DEV-1:0]           dev_ready,
    output logic                       PL19_INPUT,
    output logic [$clog2(N_DEV)-1:0]   grant,
    output logic                       busy,
    output logic                       char_done
);

    localparam int GW = $clog2(N_DEV);
    localparam int BW = $clog2(CODE_W + 1);

    acc_seq_state_t    state_q;
    logic [CODE_W-1:0] shreg_q;
    logic [BW-1:0]     bitcnt_q;
    logic              stop_pend_q;
    logic [GW-1:0]     last_grant_q;
    logic [GW-1:0]     grant_q;
    logic              char_done_q;

    logic [GW-1:0]     arb_idx_d;
    logic              arb_any_d;

    rr_arbiter #(
        .N  (N_DEV),
        .IW (GW)
    ) u_arb (
        .req     (dev_valid),
        .last    (last_grant_q),
        .gnt_idx (arb_idx_d),
        .any     (arb_any_d)
    );

    // Session FSM: arbitrate, capture one code, shift it out MSB-first on qualified cycles
    always_ff @(posedge CLOCK or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            bitcnt_q     <= '0;
            stop_pend_q  <= 1'b0;
            last_grant_q <= GW'(N_DEV - 1);
            grant_q      <= '0;
            char_done_q  <= 1'b0;
        end else begin
            char_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_input && !stop_input) begin
                        state_q <= ARB;
                    end
                end
                ARB: begin
                    // A stop seen here or earlier in the session closes before the next character
                    if (stop_pend_q || stop_input) begin
                        state_q     <= IDLE;
                        stop_pend_q <= 1'b0;
                    end else if (arb_any_d) begin
                        grant_q      <= arb_idx_d;
                        last_grant_q <= arb_idx_d;
                        state_q      <= LOAD;
                    end
                end
                LOAD: begin
                    shreg_q  <= dev_data[int'(grant_q)*CODE_W +: CODE_W];
                    bitcnt_q <= BW'(CODE_W);
                    state_q  <= SHIFT;
                    if (stop_input) begin
                        stop_pend_q <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (stop_input) begin
                        stop_pend_q <= 1'b1;
                    end
                    if (shift_m20 && (bitcnt_q != '0)) begin
                        shreg_q  <= {shreg_q[CODE_W-2:0], 1'b0};
                        bitcnt_q <= bitcnt_q - 1'b1;
                        if (bitcnt_q == BW'(1)) begin
                            state_q     <= ARB;
                            char_done_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Accept strobe and serial bit are decoded directly from state so they track shift_m20
    always_comb begin
        dev_ready  = '0;
        if (state_q == LOAD) begin
            dev_ready = N_DEV'(1) << grant_q;
        end
        PL19_INPUT = shreg_q[CODE_W-1] & shift_m20 & (state_q == SHIFT);
    end

    assign grant     = grant_q;
    assign busy      = (state_q != IDLE);
    assign char_done = char_done_q;

endmodule

// File: tb/tb_accessory_input_sequencer.sv
// tb/tb_accessory_input_sequencer.sv - randomized self-checking bench for accessory_input_sequencer
module tb_accessory_input_sequencer;

    localparam int N  = 2;
    localparam int CW = 5;

    logic          CLOCK = 1'b0;
    logic          rst;
    logic          start_input;
    logic          stop_input;
    logic          shift_m20;
    logic [N-1:0]  dev_valid;
    logic [N*CW-1:0] dev_data;
    logic [N-1:0]  dev_ready;
    logic          PL19_INPUT;
    logic [0:0]    grant;
    logic          busy;
    logic          char_done;

    int n_assert = 0;
    int n_fail   = 0;
    int last_m;

    accessory_input_sequencer #(.N_DEV(N), .CODE_W(CW)) dut (
        .CLOCK       (CLOCK),
        .rst         (rst),
        .start_input (start_input),
        .stop_input  (stop_input),
        .shift_m20   (shift_m20),
        .dev_valid   (dev_valid),
        .dev_data    (dev_data),
        .dev_ready   (dev_ready),
        .PL19_INPUT  (PL19_INPUT),
        .grant       (grant),
        .busy        (busy),
        .char_done   (char_done)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic tick;
        @(posedge CLOCK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Round-robin winner: first requesting device after the previous winner, wrapping
    function automatic int model_pick(input logic [N-1:0] mask);
        for (int off = 1; off <= N; off++) begin
            if (mask[(last_m + off) % N]) return (last_m + off) % N;
        end
        return -1;
    endfunction

    // Runs one character starting from an ARB cycle; ends in the cycle showing char_done
    task automatic do_char(input logic [N-1:0] mask, input logic [N*CW-1:0] data,
                           input int stop_at, input logic hold_start);
        int w;
        int k;
        int guard;
        logic [CW-1:0] code;
        logic stop_done;
        w = model_pick(mask);
        code = data[w*CW +: CW];
        dev_valid   = mask;
        dev_data    = data;
        start_input = hold_start;
        tick;
        check("load_ready", 32'(dev_ready), 32'(1 << w));
        check("load_grant", 32'(grant), 32'(w));
        last_m = w;
        tick;
        dev_valid = '0;
        k = 0;
        guard = 0;
        stop_done = 1'b0;
        while (k < CW && guard < 200) begin
            shift_m20 = (guard > 40) ? 1'b1 : 1'($urandom_range(0, 1));
            if (k == stop_at && !stop_done) begin
                stop_input = 1'b1;
                stop_done  = 1'b1;
            end
            #1;
            check("serial_bit", 32'(PL19_INPUT), shift_m20 ? 32'(code[CW-1-k]) : 32'd0);
            check("no_early_done", 32'(char_done), 32'd0);
            if (shift_m20) k++;
            tick;
            stop_input = 1'b0;
            guard++;
        end
        if (guard >= 200) check("shift_timeout", 32'(guard), 32'd0);
        shift_m20   = 1'b0;
        start_input = 1'b0;
        check("char_done", 32'(char_done), 32'd1);
        check("busy_after_char", 32'(busy), 32'd1);
    endtask

    initial begin
        logic [4:0] bits;
        rst = 1'b1; start_input = 1'b0; stop_input = 1'b0; shift_m20 = 1'b0;
        dev_valid = '0; dev_data = '0;
        last_m = N - 1;
        #2 rst = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(dev_ready), 32'd0);
        check("rst_serial", 32'(PL19_INPUT), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_done", 32'(char_done), 32'd0);
        tick;
        rst = 1'b1;

        // Directed single character, code 10110 from device 0 with shift held high
        tick;
        start_input = 1'b1; dev_valid = 2'b01; dev_data = {5'd0, 5'b10110}; shift_m20 = 1'b1;
        #1 check("c0_idle", 32'(busy), 32'd0);
        tick;
        start_input = 1'b0;
        check("c1_busy", 32'(busy), 32'd1);
        check("c1_ready", 32'(dev_ready), 32'd0);
        tick;
        check("c2_ready", 32'(dev_ready), 32'd1);
        check("c2_grant", 32'(grant), 32'd0);
        tick;
        dev_valid = '0;
        bits = 5'b10110;
        for (int i = 0; i < CW; i++) begin
            #1 check("c_bit", 32'(PL19_INPUT), 32'(bits[CW-1-i]));
            tick;
        end
        check("c8_done", 32'(char_done), 32'd1);
        check("c8_busy", 32'(busy), 32'd1);
        shift_m20 = 1'b0;
        last_m = 0;

        // Random masks, data and gapped shift pattern; start held during some characters
        for (int i = 0; i < 12; i++) begin
            do_char(N'($urandom_range(1, 3)), (N*CW)'($urandom), -1, (i % 4) == 0);
        end

        // Stop raised at the second bit: character completes, session then closes
        do_char(2'b11, (N*CW)'($urandom), 1, 1'b0);
        dev_valid = 2'b11;
        tick;
        check("stop_closed", 32'(busy), 32'd0);
        check("stop_no_ready", 32'(dev_ready), 32'd0);
        tick;
        check("stop_still_idle", 32'(busy), 32'd0);
        check("stop_no_ready2", 32'(dev_ready), 32'd0);
        dev_valid = '0;

        // Start and stop together in IDLE are ignored; stop in ARB closes next edge
        start_input = 1'b1; stop_input = 1'b1;
        tick;
        start_input = 1'b0; stop_input = 1'b0;
        check("start_stop_idle", 32'(busy), 32'd0);
        start_input = 1'b1;
        tick;
        start_input = 1'b0;
        check("start_opens", 32'(busy), 32'd1);
        stop_input = 1'b1;
        tick;
        stop_input = 1'b0;
        check("stop_in_arb", 32'(busy), 32'd0);
        start_input = 1'b1;
        tick;
        start_input = 1'b0;
        do_char(2'b11, (N*CW)'($urandom), -1, 1'b0);

        // Asynchronous reset in the middle of a character
        dev_valid = 2'b11; dev_data = (N*CW)'($urandom);
        tick;
        tick;
        dev_valid = '0; shift_m20 = 1'b1;
        tick;
        tick;
        #3 rst = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_serial", 32'(PL19_INPUT), 32'd0);
        check("arst_ready", 32'(dev_ready), 32'd0);
        check("arst_grant", 32'(grant), 32'd0);
        check("arst_done", 32'(char_done), 32'd0);
        shift_m20 = 1'b0;
        tick;
        rst = 1'b1;
        last_m = N - 1;
        tick;
        check("arst_no_reissue", 32'(dev_ready), 32'd0);
        start_input = 1'b1;
        tick;
        start_input = 1'b0;

        // Round robin with both devices valid: winners 0,1,0
        for (int i = 0; i < 3; i++) begin
            do_char(2'b11, {5'h01, 5'h1F}, -1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
